// File: rtl/ssram_port_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a byte-lane SSRAM.
// Grants are combinational; read-data valid is routed back one cycle after the grant.
module ssram_port_arbiter #(
  parameter int AW       = 12,
  parameter int MAX_LOCK = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          p0_req,
  input  logic          p0_lock,
  input  logic [AW-3:0] p0_addr,
  input  logic [3:0]    p0_en,
  input  logic [3:0]    p0_wb,
  input  logic [31:0]   p0_din,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_dout,
  input  logic          p1_req,
  input  logic          p1_lock,
  input  logic [AW-3:0] p1_addr,
  input  logic [3:0]    p1_en,
  input  logic [3:0]    p1_wb,
  input  logic [31:0]   p1_din,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_dout,
  output logic [AW-3:0] sram_addr,
  output logic [3:0]    sram_enb,
  output logic [3:0]    sram_wb,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout,
  input  logic          cnt_clr,
  output logic [15:0]   conflict_cnt
);

  localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK);

  logic       last_gnt;
  logic       lock_act;
  logic [7:0] lock_cnt;
  logic [1:0] rd_pend;

  logic       any_req;
  logic       both_req;
  logic       sel;
  logic       sel_lock;
  logic [3:0] sel_en;
  logic [3:0] sel_wb;
  logic [1:0] rd_next;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign any_req  = p0_req | p1_req;
  assign both_req = p0_req & p1_req;

  // With no request, sel stays on last_gnt so the address/data mux is stable.
  always_comb begin
    sel = last_gnt;
    if (both_req)
      sel = (lock_act && (lock_cnt < LOCK_LIM)) ? last_gnt : ~last_gnt;
    else if (p0_req)
      sel = 1'b0;
    else if (p1_req)
      sel = 1'b1;
  end

  assign p0_gnt   = any_req & ~sel;
  assign p1_gnt   = any_req & sel;
  assign sel_lock = sel ? p1_lock : p0_lock;
  assign sel_en   = sel ? p1_en   : p0_en;
  assign sel_wb   = sel ? p1_wb   : p0_wb;

  assign sram_addr = sel ? p1_addr : p0_addr;
  assign sram_din  = sel ? p1_din  : p0_din;
  assign sram_enb  = any_req ? sel_en : 4'h0;
  assign sram_wb   = any_req ? sel_wb : 4'h0;

  // Any lane write makes the access a write; only pure reads return rvalid.
  always_comb begin
    rd_next = 2'b00;
    if (any_req && (sel_wb == 4'h0) && (sel_en != 4'h0))
      rd_next = sel ? 2'b10 : 2'b01;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      last_gnt     <= 1'b1;
      lock_act     <= 1'b0;
      lock_cnt     <= 8'd0;
      rd_pend      <= 2'b00;
      conflict_cnt <= 16'd0;
    end else begin
      rd_pend <= rd_next;
      if (any_req) begin
        last_gnt <= sel;
        lock_act <= sel_lock;
        lock_cnt <= ((sel != last_gnt) || !lock_act) ? 8'd1 : sat_inc8(lock_cnt);
      end
      if (cnt_clr)
        conflict_cnt <= 16'd0;
      else if (both_req)
        conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end

  assign p0_rvalid = rd_pend[0];
  assign p1_rvalid = rd_pend[1];
  assign p0_dout   = sram_dout;
  assign p1_dout   = sram_dout;

endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Bench for ssram_port_arbiter: vector table, directed corner sequences and a
// randomized run against a rule-level model with a write-first bank model attached.
module tb_ssram_port_arbiter;
  localparam int AW = 12;
  localparam int MAX_LOCK = 8;

  logic HCLK, HRESET;
  logic p0_req, p0_lock, p1_req, p1_lock;
  logic [AW-3:0] p0_addr, p1_addr, sram_addr;
  logic [3:0] p0_en, p0_wb, p1_en, p1_wb, sram_enb, sram_wb;
  logic [31:0] p0_din, p1_din, p0_dout, p1_dout, sram_din, sram_dout;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic cnt_clr;
  logic [15:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  ssram_port_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_en(p0_en),
    .p0_wb(p0_wb), .p0_din(p0_din), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_en(p1_en),
    .p1_wb(p1_wb), .p1_din(p1_din), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_dout(p1_dout),
    .sram_addr(sram_addr), .sram_enb(sram_enb), .sram_wb(sram_wb),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Write-first byte-lane bank array with one-cycle registered read.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  always @(posedge HCLK) begin : bank
    logic [31:0] w;
    w = mem[sram_addr];
    for (int i = 0; i < 4; i++)
      if (sram_enb[i] && sram_wb[i]) w[8*i +: 8] = sram_din[8*i +: 8];
    mem[sram_addr] <= w;
    if (sram_enb != 4'h0) sram_dout <= w;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_lock = 0; p0_addr = '0; p0_en = 0; p0_wb = 0; p0_din = 0;
    p1_req = 0; p1_lock = 0; p1_addr = '0; p1_en = 0; p1_wb = 0; p1_din = 0;
    cnt_clr = 0;
  endtask

  task automatic drv(input int port, input logic req, input logic lock,
                     input logic [AW-3:0] addr, input logic [3:0] en,
                     input logic [3:0] wb, input logic [31:0] din);
    if (port == 0) begin
      p0_req = req; p0_lock = lock; p0_addr = addr; p0_en = en; p0_wb = wb; p0_din = din;
    end else begin
      p1_req = req; p1_lock = lock; p1_addr = addr; p1_en = en; p1_wb = wb; p1_din = din;
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    nxt();
    HRESET = 1'b0;
  endtask

  typedef struct {
    logic r0, r1;
    logic g0, g1, v0, v1;
  } vec_t;
  vec_t tbl[8];

  // Rule-level reference state.
  int m_last, m_run, m_cnt;
  bit m_lock;
  bit m_pend[2];
  logic [31:0] m_rd[2], m_mask[2];
  logic [31:0] shadow [0:1023] = '{default: 32'h0};
  logic r[2], lk[2];
  logic [AW-3:0] a[2];
  logic [3:0] e[2], wbv[2];
  logic [31:0] d[2];

  function automatic int pick();
    if (!r[0] && !r[1]) return -1;
    if (r[0] && !r[1]) return 0;
    if (!r[0] && r[1]) return 1;
    if (m_lock && m_run < MAX_LOCK) return m_last;
    return 1 - m_last;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{en[i]}};
    return m;
  endfunction

  initial begin
    int n;
    logic got;
    HRESET = 1'b0;
    idle();
    #2;
    do_reset();

    // Reset state.
    @(negedge HCLK);
    chk("rst_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk("rst_enb", {28'd0, sram_enb}, 32'd0);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    nxt();

    // Table: grant and rvalid sequence from reset, pure reads.
    tbl[0] = '{1,1, 1,0, 0,0};
    tbl[1] = '{1,1, 0,1, 1,0};
    tbl[2] = '{1,1, 1,0, 0,1};
    tbl[3] = '{1,1, 0,1, 1,0};
    tbl[4] = '{0,0, 0,0, 0,1};
    tbl[5] = '{0,1, 0,1, 0,0};
    tbl[6] = '{1,0, 1,0, 0,1};
    tbl[7] = '{0,0, 0,0, 1,0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(0, tbl[i].r0, 0, 10'(i), 4'hF, 4'h0, 0);
      drv(1, tbl[i].r1, 0, 10'(i + 8), 4'hF, 4'h0, 0);
      @(negedge HCLK);
      chk($sformatf("tbl%0d_gnt", i), {30'd0, p0_gnt, p1_gnt}, {30'd0, tbl[i].g0, tbl[i].g1});
      chk($sformatf("tbl%0d_rv", i), {30'd0, p0_rvalid, p1_rvalid}, {30'd0, tbl[i].v0, tbl[i].v1});
      nxt();
    end
    idle();
    @(negedge HCLK);
    chk("tbl_cnt", {16'd0, conflict_cnt}, 32'd4);
    nxt();

    // Write then read back on port 0.
    do_reset();
    drv(0, 1, 0, 10'h005, 4'hF, 4'hF, 32'hA5A5_1234);
    @(negedge HCLK);
    chk("wr_gnt", {31'd0, p0_gnt}, 32'd1);
    nxt();
    drv(0, 1, 0, 10'h005, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("rd_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("wr_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
    nxt();
    idle();
    @(negedge HCLK);
    chk("rd_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd2);
    chk("rd_dout", p0_dout, 32'hA5A5_1234);
    nxt();

    // Lock: p0 holds for MAX_LOCK grants, then p1 gets in.
    do_reset();
    drv(0, 1, 1, 10'h1, 4'hF, 4'h0, 0);
    drv(1, 1, 0, 10'h2, 4'hF, 4'h0, 0);
    n = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge HCLK);
      if (p1_gnt) got = 1;
      else if (p0_gnt) n++;
      nxt();
    end
    chk("lock_p1_gnt", {31'd0, got}, 32'd1);
    chk("lock_p0_run", n, MAX_LOCK);
    @(negedge HCLK);
    chk("lock_after", {30'd0, p0_gnt, p1_gnt}, 32'd2);
    nxt();
    idle();

    // Byte-lane write on port 1.
    drv(1, 1, 0, 10'h3FF, 4'hF, 4'hF, 32'hFFFF_FFFF);
    nxt();
    drv(1, 1, 0, 10'h3FF, 4'h2, 4'h2, 32'h0000_7700);
    @(negedge HCLK);
    chk("bw_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
    chk("bw_enb", {24'd0, sram_enb, sram_wb}, 32'h22);
    nxt();
    drv(1, 1, 0, 10'h3FF, 4'hF, 4'h0, 0);
    nxt();
    idle();
    @(negedge HCLK);
    chk("bw_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd1);
    chk("bw_dout", p1_dout, 32'hFFFF_77FF);
    nxt();

    // Reset during an outstanding read.
    drv(0, 1, 0, 10'h005, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("rr_gnt", {31'd0, p0_gnt}, 32'd1);
    nxt();
    HRESET = 1'b1;
    idle();
    #1;
    chk("rr_async_clr", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    nxt();
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rr_after", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    nxt();
    drv(0, 1, 0, 10'h1, 4'hF, 4'h0, 0);
    drv(1, 1, 0, 10'h2, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("rr_first_win", {30'd0, p0_gnt, p1_gnt}, 32'd2);
    nxt();

    // Conflict counter saturation and clear under contention.
    do_reset();
    repeat (65540) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    chk("cnt_sat", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    nxt();
    cnt_clr = 1;
    nxt();
    cnt_clr = 0;
    @(negedge HCLK);
    chk("cnt_clr", {16'd0, conflict_cnt}, 32'd0);
    nxt();
    @(negedge HCLK);
    chk("cnt_resume", {16'd0, conflict_cnt}, 32'd1);
    nxt();
    idle();

    // Randomized run against the reference model.
    do_reset();
    m_last = 1; m_lock = 0; m_run = 0; m_cnt = 0;
    m_pend[0] = 0; m_pend[1] = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      int src;
      for (int p = 0; p < 2; p++) begin
        r[p]   = ($urandom_range(0, 3) != 0);
        lk[p]  = ($urandom_range(0, 2) == 0);
        a[p]   = 10'($urandom_range(0, 7));
        e[p]   = 4'($urandom);
        wbv[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : (4'($urandom) & e[p]);
        d[p]   = $urandom;
        drv(p, r[p], lk[p], a[p], e[p], wbv[p], d[p]);
      end
      cnt_clr = ($urandom_range(0, 15) == 0);
      g = pick();
      src = (g < 0) ? m_last : g;
      @(negedge HCLK);
      chk("rnd_gnt", {30'd0, p0_gnt, p1_gnt}, {30'd0, g == 0, g == 1});
      chk("rnd_enb_wb", {24'd0, sram_enb, sram_wb},
          (g < 0) ? 32'd0 : {24'd0, e[g], wbv[g]});
      chk("rnd_addr", {22'd0, sram_addr}, {22'd0, a[src]});
      chk("rnd_din", sram_din, d[src]);
      chk("rnd_rvalid", {30'd0, p0_rvalid, p1_rvalid}, {30'd0, m_pend[0], m_pend[1]});
      if (m_pend[0]) chk("rnd_dout0", p0_dout & m_mask[0], m_rd[0] & m_mask[0]);
      if (m_pend[1]) chk("rnd_dout1", p1_dout & m_mask[1], m_rd[1] & m_mask[1]);
      chk("rnd_cnt", {16'd0, conflict_cnt}, m_cnt);
      m_pend[0] = 0; m_pend[1] = 0;
      if (g >= 0) begin
        if (g != m_last || !m_lock) m_run = 1;
        else m_run++;
        m_last = g;
        m_lock = lk[g];
        if (wbv[g] == 4'h0 && e[g] != 4'h0) begin
          m_pend[g] = 1;
          m_rd[g] = shadow[a[g]];
          m_mask[g] = lane_mask(e[g]);
        end else begin
          for (int l = 0; l < 4; l++)
            if (e[g][l] && wbv[g][l]) shadow[a[g]][8*l +: 8] = d[g][8*l +: 8];
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (r[0] && r[1] && m_cnt < 65535) m_cnt++;
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
